// File: rtl/aes_job_scheduler_if.sv
// Host-side and core-side signals of the AES job scheduler.
// slave is the scheduler's view; master is the view of whatever surrounds it.
interface aes_job_scheduler_if;
    logic [1:0] req;
    logic [1:0] req_mode;
    logic [1:0] gnt;
    logic [7:0] din0;
    logic [7:0] din1;
    logic [1:0] din_valid;
    logic [1:0] din_ready;
    logic [7:0] dout;
    logic [1:0] dout_valid;
    logic [1:0] done;
    logic       err;
    logic       busy;
    logic       core_start;
    logic       core_mode;
    logic [7:0] core_data;
    logic [7:0] core_z;
    logic       core_z_ready;

    modport slave (
        input  req,
        input  req_mode,
        input  din0,
        input  din1,
        input  din_valid,
        input  core_z,
        input  core_z_ready,
        output gnt,
        output din_ready,
        output dout,
        output dout_valid,
        output done,
        output err,
        output busy,
        output core_start,
        output core_mode,
        output core_data
    );

    modport master (
        output req,
        output req_mode,
        output din0,
        output din1,
        output din_valid,
        output core_z,
        output core_z_ready,
        input  gnt,
        input  din_ready,
        input  dout,
        input  dout_valid,
        input  done,
        input  err,
        input  busy,
        input  core_start,
        input  core_mode,
        input  core_data
    );
endinterface

// File: rtl/aes_job_scheduler.sv
// Round-robin sharing of one byte-serial AES core between two requesters:
// grant, 16-byte load, run, 16-byte drain, cool-down until the core can restart.
module aes_job_scheduler #(
    parameter int unsigned NBYTES     = 16,
    parameter int unsigned JOB_CYCLES = 180,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic                clk,
    input logic                rst,
    aes_job_scheduler_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(NBYTES + 1);
    localparam int unsigned CYC_W = 8;
    localparam logic [CYC_W-1:0] CYC_MAX  = '1;
    localparam logic [CYC_W-1:0] COOL_END = CYC_W'(JOB_CYCLES - 1);
    localparam logic [CYC_W-1:0] TMO_END  = CYC_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_COOL
    } state_e;

    state_e           state_q,   state_d;
    logic             ptr_q,     ptr_d;
    logic             owner_q,   owner_d;
    logic [1:0]       gnt_q,     gnt_d;
    logic             mode_q,    mode_d;
    logic             started_q, started_d;
    logic             abort_q,   abort_d;
    logic             tmo_q,     tmo_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CYC_W-1:0] cyc_q,     cyc_d;

    logic       own_valid_c;
    logic [7:0] own_din_c;
    logic       cool_exit_c;
    logic       core_start_c;
    logic [7:0] core_data_c;

    // Owner's input stream and the end-of-job condition
    always_comb begin
        own_valid_c = owner_q ? bus.din_valid[1] : bus.din_valid[0];
        own_din_c   = owner_q ? bus.din1 : bus.din0;
        cool_exit_c = (state_q == S_COOL) && (tmo_q || (cyc_q >= COOL_END));
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        gnt_d        = gnt_q;
        mode_d       = mode_q;
        started_d    = started_q;
        abort_d      = abort_q;
        tmo_d        = tmo_q;
        cnt_d        = cnt_q;
        cyc_d        = cyc_q;
        core_start_c = 1'b0;
        core_data_c  = 8'h00;

        case (state_q)
            S_IDLE: begin
                cyc_d     = '0;
                cnt_d     = '0;
                started_d = 1'b0;
                abort_d   = 1'b0;
                tmo_d     = 1'b0;
                if (bus.req != 2'b00) begin
                    owner_d = (bus.req == 2'b11) ? ptr_q : bus.req[1];
                    gnt_d   = owner_d ? 2'b10 : 2'b01;
                    mode_d  = owner_d ? bus.req_mode[1] : bus.req_mode[0];
                    ptr_d   = ~owner_d;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                if (!started_q) begin
                    // The first beat starts the core; waiting for it is unbounded
                    if (own_valid_c) begin
                        core_start_c = 1'b1;
                        core_data_c  = own_din_c;
                        started_d    = 1'b1;
                        cnt_d        = CNT_W'(1);
                    end
                end else begin
                    // Core consumes a byte every cycle; a gap poisons the rest of the job
                    if (own_valid_c && !abort_q) begin
                        core_data_c = own_din_c;
                    end else begin
                        abort_d = 1'b1;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (bus.core_z_ready) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else if (cyc_q >= TMO_END) begin
                    abort_d = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = S_COOL;
                end
            end

            S_DRAIN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BEAT) begin
                    cnt_d   = '0;
                    state_d = S_COOL;
                end
            end

            S_COOL: begin
                if (cool_exit_c) begin
                    gnt_d   = 2'b00;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // cyc counts cycles since core_start, saturating
        if ((state_q != S_IDLE) && (started_q || core_start_c) && (cyc_q != CYC_MAX)) begin
            cyc_d = cyc_q + CYC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            gnt_q     <= 2'b00;
            mode_q    <= 1'b0;
            started_q <= 1'b0;
            abort_q   <= 1'b0;
            tmo_q     <= 1'b0;
            cnt_q     <= '0;
            cyc_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            gnt_q     <= gnt_d;
            mode_q    <= mode_d;
            started_q <= started_d;
            abort_q   <= abort_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            cyc_q     <= cyc_d;
        end
    end

    // Outputs are decoded from state flops; core_start/core_data follow the first beat
    assign bus.gnt        = gnt_q;
    assign bus.core_mode  = mode_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.din_ready  = ((state_q == S_LOAD) && !abort_q) ? gnt_q : 2'b00;
    assign bus.dout_valid = ((state_q == S_DRAIN) && !abort_q) ? gnt_q : 2'b00;
    assign bus.dout       = (state_q == S_DRAIN) ? bus.core_z : 8'h00;
    assign bus.done       = cool_exit_c ? gnt_q : 2'b00;
    assign bus.err        = cool_exit_c && abort_q;
    assign bus.core_start = core_start_c;
    assign bus.core_data  = core_data_c;
endmodule

// File: tb/tb_aes_job_scheduler.sv
// Bench for aes_job_scheduler: behavioural byte-serial core, two host requesters,
// scoreboard of expected result bytes checked as dout_valid strobes arrive.
module tb_aes_job_scheduler;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    aes_job_scheduler_if bus();

    aes_job_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] core_fn(input logic [7:0] b, input int i, input logic m);
        return (b ^ (m ? 8'h5A : 8'hC3)) + 8'(i * 7);
    endfunction

    // Core model: captures 16 bytes from core_start, pulses ready after core_lat
    // further cycles, then streams the transformed bytes.
    int         core_lat = 20;
    int         ct;
    bit         c_act;
    logic       c_mode;
    logic [7:0] c_mem [16];
    int         zr;
    int         zi;
    logic       z_ready_m;
    logic [7:0] z_m;

    always @(posedge clk) begin
        if (!rst) begin
            c_act <= 1'b0;
            ct    <= 0;
        end else if (bus.core_start) begin
            c_act    <= 1'b1;
            ct       <= 1;
            c_mem[0] <= bus.core_data;
            c_mode   <= bus.core_mode;
        end else if (c_act) begin
            if (ct < 16) c_mem[ct] <= bus.core_data;
            ct <= ct + 1;
            if (ct > 1000) c_act <= 1'b0;
        end
    end

    always_comb begin
        zr        = 16 + core_lat;
        zi        = ct - zr - 1;
        z_ready_m = c_act && (core_lat >= 0) && (ct == zr);
        z_m       = 8'h00;
        if (c_act && (core_lat >= 0) && (zi >= 0) && (zi < 16))
            z_m = core_fn(c_mem[zi[3:0]], zi, c_mode);
    end

    assign bus.core_z       = z_m;
    assign bus.core_z_ready = z_ready_m;

    // Scoreboard of expected dout bytes for the current owner
    logic [7:0] sb_q [$];
    logic [1:0] exp_oh = 2'b00;

    always @(negedge clk) begin
        if (rst === 1'b1 && bus.dout_valid != 2'b00) begin
            check("dout_owner", 32'(bus.dout_valid), 32'(exp_oh));
            if (sb_q.size() == 0) check("dout_unexp", 32'(bus.dout_valid), 32'h0);
            else                  check("dout", 32'(bus.dout), 32'(sb_q.pop_front()));
        end
    end

    // Consecutive core_starts must be at least JOB_CYCLES apart
    int cyc_cnt = 0;
    int last_start = -1;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            last_start = -1;
        end else if (bus.core_start) begin
            if (last_start >= 0) check("start_spacing", 32'((cyc_cnt - last_start) >= 180), 32'h1);
            last_start = cyc_cnt;
        end
    end

    task automatic set_din(input int owner, input logic [7:0] b, input logic v);
        bus.din0      = (owner == 0) ? b : 8'h00;
        bus.din1      = (owner == 1) ? b : 8'h00;
        bus.din_valid = v ? 2'(1 << owner) : 2'b00;
    endtask

    int seed = 0;

    // One job: wait for grant, stream 16 beats (optionally with a gap), wait for done
    task automatic do_job(input logic [1:0] rq, input bit drop, input int owner,
                          input int gap_at, input int lat, input logic exp_err);
        logic [1:0] oh;
        logic [1:0] rm_saved;
        logic       mode;
        logic [7:0] b;
        int         n;
        int         bad_mode;
        int         exp_n;
        oh       = 2'(1 << owner);
        rm_saved = bus.req_mode;
        mode     = rm_saved[owner];
        bad_mode = 0;
        exp_n    = (lat < 0) ? 256 : 179;
        core_lat = lat;
        exp_oh   = oh;
        bus.req  = rq;

        n = 0;
        while (bus.gnt == 2'b00 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        check("gnt", 32'(bus.gnt), 32'(oh));
        if (drop) bus.req = 2'b00;
        bus.req_mode = ~rm_saved;

        for (int i = 0; i < 16; i++) begin
            b = 8'(seed + i);
            set_din(owner, b, (gap_at == 0) || (i < gap_at));
            #1;
            if (i == 0) begin
                check("core_start", 32'(bus.core_start), 32'h1);
                check("din_ready", 32'(bus.din_ready), 32'(oh));
                check("busy", 32'(bus.busy), 32'h1);
            end
            if (i == 1) check("core_start_once", 32'(bus.core_start), 32'h0);
            if (gap_at != 0 && i == gap_at + 1) check("din_ready_abort", 32'(bus.din_ready), 32'h0);
            if (bus.core_mode !== mode) bad_mode++;
            if (!exp_err) sb_q.push_back(core_fn(b, i, mode));
            @(posedge clk); #2;
        end
        set_din(owner, 8'h00, 1'b0);
        seed = seed + 8'h11;

        n = 16;
        while (bus.done == 2'b00 && n < 400) begin
            if (bus.core_mode !== mode) bad_mode++;
            @(posedge clk); #2;
            n++;
        end
        check("done_cyc", 32'(n), 32'(exp_n));
        check("done", 32'(bus.done), 32'(oh));
        check("err", 32'(bus.err), 32'(exp_err));
        check("core_mode_held", 32'(bad_mode), 32'h0);
        check("sb_empty", 32'(sb_q.size()), 32'h0);
        sb_q.delete();
        bus.req_mode = rm_saved;
        @(posedge clk); #2;
        check("idle_gap", 32'({bus.busy, bus.gnt}), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b0;
        bus.req       = 2'b00;
        bus.req_mode  = 2'b00;
        set_din(0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        rst = 1'b1;

        // Reset in the middle of LOAD, with owner 0 still driving beats
        bus.req = 2'b01;
        @(posedge clk); #2;
        check("pre_gnt", 32'(bus.gnt), 32'h1);
        for (int i = 0; i < 3; i++) begin
            set_din(0, 8'(8'hE0 + i), 1'b1);
            @(posedge clk); #2;
        end
        rst     = 1'b0;
        bus.req = 2'b11;
        repeat (3) @(posedge clk);
        #2;
        check("mid_rst_gnt", 32'(bus.gnt), 32'h0);
        check("mid_rst_din_ready", 32'(bus.din_ready), 32'h0);
        check("mid_rst_dout_valid", 32'(bus.dout_valid), 32'h0);
        check("mid_rst_done", 32'(bus.done), 32'h0);
        check("mid_rst_err", 32'(bus.err), 32'h0);
        check("mid_rst_busy", 32'(bus.busy), 32'h0);
        check("mid_rst_core_start", 32'(bus.core_start), 32'h0);
        set_din(0, 8'h00, 1'b0);
        rst = 1'b1;

        // Single encrypt on owner 0: both request, reset pointer must pick 0; bytes 00..0F
        bus.req_mode = 2'b00;
        do_job(2'b11, 1'b1, 0, 0, 20, 1'b0);

        // Decrypt on owner 1
        bus.req_mode = 2'b10;
        do_job(2'b10, 1'b1, 1, 0, 25, 1'b0);

        // Contention: both held, grants alternate starting from owner 0
        for (int k = 0; k < 4; k++) begin
            do_job(2'b11, 1'b0, k % 2, 0, 18 + 3 * k, 1'b0);
        end

        // Load gap after beat 5, then a normal job
        bus.req_mode = 2'b00;
        do_job(2'b01, 1'b1, 0, 5, 20, 1'b1);
        bus.req_mode = 2'b10;
        do_job(2'b10, 1'b1, 1, 0, 30, 1'b0);

        // Core never answers: timeout, then recovery
        bus.req_mode = 2'b00;
        do_job(2'b01, 1'b1, 0, 0, -1, 1'b1);
        do_job(2'b10, 1'b1, 1, 0, 22, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
